// File: rtl/concat_pkg.sv
// Shared definitions for the two-beat packed lane link receive path:
// default widths, the frame-assembly state encoding and the lane bit-reversal helper.
package concat_pkg;

  localparam int WORD_W_DEF = 11;
  localparam int LANE_W_DEF = 6;
  localparam int TAG_W_DEF  = 4;
  localparam int ERR_W_DEF  = 8;

  // Widest lane the reversal helper can handle.
  localparam int MAX_LANE_W = 32;
  localparam int LANE_IDX_W = $clog2(MAX_LANE_W);

  // S_LO waits for the first beat of a frame; S_HI holds W0 and waits for the completing beat.
  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } state_e;

  // Reverse the low w bits of v (bit i takes bit w-1-i); bits at and above w come back zero.
  function automatic logic [MAX_LANE_W-1:0] bitrev_lane(input logic [MAX_LANE_W-1:0] v,
                                                        input int                    w);
    logic [MAX_LANE_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LANE_W; i++) begin
      if (i < w) begin
        r[LANE_IDX_W'(i)] = v[LANE_IDX_W'(w - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/concat_unpack_if.sv
// Packed-word input stream and unpacked lane output stream of the lane unpacker.
// The master side is whoever drives packed words and drains lanes; the slave side is the unpacker.
interface concat_unpack_if
  import concat_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int ERR_W  = ERR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_first;

  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_l0;
  logic [LANE_W-1:0] out_l1;
  logic [LANE_W-1:0] out_l2;
  logic [TAG_W-1:0]  out_tag;

  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output in_valid, in_data, in_first, out_ready,
    input  in_ready, out_valid, out_l0, out_l1, out_l2, out_tag, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_first, out_ready,
    output in_ready, out_valid, out_l0, out_l1, out_l2, out_tag, err_cnt
  );

endinterface

// File: rtl/concat_unpack_slice.sv
// Pure combinational scatter of one reassembled frame {W0,W1} into three lanes and a tag.
// Lanes are taken MSB-first from the frame; the tag is the bottom TAG_W bits and is never reversed.
module concat_unpack_slice
  import concat_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int LANE_W       = LANE_W_DEF,
  parameter int TAG_W        = TAG_W_DEF,
  parameter bit REVERSE_LANE = 1'b0
) (
  input  logic [2*WORD_W-1:0] frame_i,
  output logic [LANE_W-1:0]   l0_o,
  output logic [LANE_W-1:0]   l1_o,
  output logic [LANE_W-1:0]   l2_o,
  output logic [TAG_W-1:0]    tag_o
);

  localparam int FRAME_W = 2 * WORD_W;

  logic [LANE_W-1:0] raw_l0;
  logic [LANE_W-1:0] raw_l1;
  logic [LANE_W-1:0] raw_l2;

  assign raw_l0 = frame_i[FRAME_W-1            -: LANE_W];
  assign raw_l1 = frame_i[FRAME_W-1-LANE_W     -: LANE_W];
  assign raw_l2 = frame_i[FRAME_W-1-2*LANE_W   -: LANE_W];
  assign tag_o  = frame_i[TAG_W-1:0];

  if (LANE_W > MAX_LANE_W) begin : g_lane_w_check
    $error("concat_unpack_slice: LANE_W exceeds MAX_LANE_W");
  end

  // Reversal undoes LSB-first packing on the sender side; only lanes are affected.
  if (REVERSE_LANE) begin : g_rev
    assign l0_o = LANE_W'(bitrev_lane(MAX_LANE_W'(raw_l0), LANE_W));
    assign l1_o = LANE_W'(bitrev_lane(MAX_LANE_W'(raw_l1), LANE_W));
    assign l2_o = LANE_W'(bitrev_lane(MAX_LANE_W'(raw_l2), LANE_W));
  end else begin : g_fwd
    assign l0_o = raw_l0;
    assign l1_o = raw_l1;
    assign l2_o = raw_l2;
  end

endmodule

// File: rtl/concat_unpack.sv
// Receive side of the two-beat packed lane link: reassembles {W0,W1} frames from a valid/ready
// stream of packed words, scatters them into three lanes plus a tag behind a one-deep output
// register, and counts framing errors in a saturating counter.
module concat_unpack
  import concat_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int LANE_W       = LANE_W_DEF,
  parameter int TAG_W        = TAG_W_DEF,
  parameter bit REVERSE_LANE = 1'b0,
  parameter int ERR_W        = ERR_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  concat_unpack_if.slave  bus
);

  if (2 * WORD_W != 3 * LANE_W + TAG_W) begin : g_width_check
    $error("concat_unpack: 2*WORD_W must equal 3*LANE_W+TAG_W");
  end

  state_e            state_q;
  logic [WORD_W-1:0] w0_q;

  logic              out_valid_q, out_valid_d;
  logic [LANE_W-1:0] l0_q, l1_q, l2_q;
  logic [TAG_W-1:0]  tag_q;

  logic [ERR_W-1:0]  err_q, err_d;

  logic              in_ready;
  logic              accept;
  logic              load;
  logic              frame_err;

  logic [LANE_W-1:0] x_l0, x_l1, x_l2;
  logic [TAG_W-1:0]  x_tag;

  // Only the completing beat needs room in the output register; a first beat is always taken.
  assign in_ready  = (state_q == S_LO) || !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign load      = accept && (state_q == S_HI) && !bus.in_first;
  // Orphan second beat in S_LO, or a new first beat restarting the frame in S_HI.
  assign frame_err = accept && (((state_q == S_LO) && !bus.in_first) ||
                                ((state_q == S_HI) &&  bus.in_first));

  // Scatter the frame formed by the held W0 and the beat currently on the bus.
  concat_unpack_slice #(
    .WORD_W       (WORD_W),
    .LANE_W       (LANE_W),
    .TAG_W        (TAG_W),
    .REVERSE_LANE (REVERSE_LANE)
  ) u_slice (
    .frame_i ({w0_q, bus.in_data}),
    .l0_o    (x_l0),
    .l1_o    (x_l1),
    .l2_o    (x_l2),
    .tag_o   (x_tag)
  );

  // Frame-assembly FSM: tracks which beat is expected and holds W0 between beats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LO;
      w0_q    <= '0;
    end else if (accept) begin
      case (state_q)
        S_LO: begin
          if (bus.in_first) begin
            w0_q    <= bus.in_data;
            state_q <= S_HI;
          end
        end
        S_HI: begin
          if (bus.in_first) begin
            w0_q <= bus.in_data;
          end else begin
            state_q <= S_LO;
          end
        end
        default: state_q <= S_LO;
      endcase
    end
  end

  // Next output-valid and saturating error count.
  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    out_valid_d = load || (out_valid_q && !bus.out_ready);
    err_d       = err_q;
    if (frame_err && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Output register (holds under backpressure) and framing-error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      l0_q        <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      tag_q       <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (load) begin
        l0_q  <= x_l0;
        l1_q  <= x_l1;
        l2_q  <= x_l2;
        tag_q <= x_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_l0    = l0_q;
  assign bus.out_l1    = l1_q;
  assign bus.out_l2    = l2_q;
  assign bus.out_tag   = tag_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_concat_unpack.sv
// Directed bench for concat_unpack. Three instances share one stimulus stream: default
// configuration, lane reversal enabled, and a 2-bit error counter for saturation. A small
// reference model predicts in_ready/out_valid/err_cnt each cycle and a scoreboard queue holds
// the expected lane sets in completion order.
module tb_concat_unpack;

  typedef struct packed {
    logic [5:0] l0;
    logic [5:0] l1;
    logic [5:0] l2;
    logic [3:0] tag;
  } lanes_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic [10:0] in_data = '0;
  logic        out_ready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_hi;
  bit          m_ov;
  bit          m_acc;
  logic [10:0] m_w0;
  int          m_err;
  lanes_t      sb[$];

  always #5 clk = ~clk;

  concat_unpack_if #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .ERR_W(8)) bus_a ();
  concat_unpack_if #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .ERR_W(8)) bus_r ();
  concat_unpack_if #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .ERR_W(2)) bus_s ();

  assign bus_a.in_valid = in_valid;  assign bus_a.in_first = in_first;
  assign bus_a.in_data  = in_data;   assign bus_a.out_ready = out_ready;
  assign bus_r.in_valid = in_valid;  assign bus_r.in_first = in_first;
  assign bus_r.in_data  = in_data;   assign bus_r.out_ready = out_ready;
  assign bus_s.in_valid = in_valid;  assign bus_s.in_first = in_first;
  assign bus_s.in_data  = in_data;   assign bus_s.out_ready = out_ready;

  concat_unpack #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .REVERSE_LANE(1'b0), .ERR_W(8))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  concat_unpack #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .REVERSE_LANE(1'b1), .ERR_W(8))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  concat_unpack #(.WORD_W(11), .LANE_W(6), .TAG_W(4), .REVERSE_LANE(1'b0), .ERR_W(2))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  function automatic lanes_t expect_lanes(input logic [10:0] w0, input logic [10:0] w1);
    logic [21:0] f;
    lanes_t      e;
    f     = {w0, w1};
    e.l0  = f[21:16];
    e.l1  = f[15:10];
    e.l2  = f[9:4];
    e.tag = f[3:0];
    return e;
  endfunction

  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5 - i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    bit     rdy;
    bit     load;
    lanes_t e;
    @(negedge clk);
    rdy = !m_hi || !m_ov || out_ready;
    check("in_ready",  32'(bus_a.in_ready),  32'(rdy));
    check("out_valid", 32'(bus_a.out_valid), 32'(m_ov));
    check("err_cnt",   32'(bus_a.err_cnt),   32'(m_err));
    check("err_sat",   32'(bus_s.err_cnt),   32'((m_err > 3) ? 3 : m_err));
    if (m_ov && sb.size() > 0) begin
      e = sb[0];
      check("l0",     32'(bus_a.out_l0),  32'(e.l0));
      check("l1",     32'(bus_a.out_l1),  32'(e.l1));
      check("l2",     32'(bus_a.out_l2),  32'(e.l2));
      check("tag",    32'(bus_a.out_tag), 32'(e.tag));
      check("rev_l0", 32'(bus_r.out_l0),  32'(rev6(e.l0)));
      check("rev_l1", 32'(bus_r.out_l1),  32'(rev6(e.l1)));
      check("rev_l2", 32'(bus_r.out_l2),  32'(rev6(e.l2)));
      check("rev_tag",32'(bus_r.out_tag), 32'(e.tag));
      if (out_ready) void'(sb.pop_front());
    end
    m_acc = in_valid && rdy;
    load  = 1'b0;
    if (m_acc) begin
      if (!m_hi) begin
        if (in_first) begin m_w0 = in_data; m_hi = 1'b1; end
        else m_err++;
      end else begin
        if (in_first) begin m_err++; m_w0 = in_data; end
        else begin
          sb.push_back(expect_lanes(m_w0, in_data));
          m_hi = 1'b0;
          load = 1'b1;
        end
      end
    end
    m_ov = load || (m_ov && !out_ready);
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted, with a bounded wait.
  task automatic send(input bit first, input logic [10:0] data, output int waited);
    in_valid = 1'b1;
    in_first = first;
    in_data  = data;
    waited   = 0;
    forever begin
      cycle();
      if (m_acc) break;
      waited++;
      if (waited > 20) begin
        n_assert++;
        n_fail++;
        $error("FAIL accept_timeout: observed no accept after %0d cycles, expected accept", waited);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Idle cycles with junk on the data/first lines, which must be ignored.
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data  = 11'($urandom);
      in_first = 1'($urandom);
      cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_err_cnt",   32'(bus_a.err_cnt),   32'd0);
    check("rst_err_sat",   32'(bus_s.err_cnt),   32'd0);
    check("rst_lanes",     32'({bus_a.out_l0, bus_a.out_l1, bus_a.out_l2, bus_a.out_tag}), 32'd0);
    m_hi  = 1'b0;
    m_ov  = 1'b0;
    m_err = 0;
    m_w0  = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
  endtask

  initial begin
    int w;

    // 1: reset state
    m_hi = 1'b0; m_ov = 1'b0; m_err = 0; m_w0 = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // 2/3: basic frame, plain and reversed
    out_ready = 1'b1;
    send(1'b1, 11'h5A3, w);
    send(1'b0, 11'h2C7, w);
    check("basic_valid", 32'(bus_a.out_valid), 32'd1);
    check("basic_l0",    32'(bus_a.out_l0),  32'h2D);
    check("basic_l1",    32'(bus_a.out_l1),  32'h06);
    check("basic_l2",    32'(bus_a.out_l2),  32'h2C);
    check("basic_tag",   32'(bus_a.out_tag), 32'h7);
    check("rev_basic",   32'({bus_r.out_l0, bus_r.out_l1, bus_r.out_l2, bus_r.out_tag}),
                         32'({6'h2D, 6'h18, 6'h0D, 4'h7}));
    idle(3);

    // 4: backpressure, first frame held, second W1 stalls, then load and drain together
    out_ready = 1'b0;
    send(1'b1, 11'h123, w);
    send(1'b0, 11'h456, w);
    send(1'b1, 11'h7AB, w);
    check("beat0_no_stall", 32'(w), 32'd0);
    in_valid = 1'b1;
    in_first = 1'b0;
    in_data  = 11'h0CD;
    repeat (3) cycle();
    out_ready = 1'b1;
    send(1'b0, 11'h0CD, w);
    check("release_accept", 32'(w), 32'd0);
    idle(3);

    // 5: framing errors, orphan W1 then restarted frame
    send(1'b0, 11'h3FF, w);
    send(1'b1, 11'h111, w);
    send(1'b1, 11'h222, w);
    send(1'b0, 11'h333, w);
    idle(2);

    // Reset mid-frame with a held output: nothing is emitted afterwards
    out_ready = 1'b0;
    send(1'b1, 11'h0F0, w);
    send(1'b0, 11'h30F, w);
    send(1'b1, 11'h555, w);
    do_reset();
    out_ready = 1'b1;
    idle(3);

    // 6: saturation of the 2-bit counter, then full-rate back-to-back frames
    for (int i = 0; i < 5; i++) send(1'b0, 11'($urandom), w);
    check("sat_narrow", 32'(bus_s.err_cnt), 32'd3);
    check("sat_wide",   32'(bus_a.err_cnt), 32'd5);
    for (int k = 0; k < 6; k++) begin
      send(1'b1, 11'($urandom), w);
      check("rate_beat0", 32'(w), 32'd0);
      send(1'b0, 11'($urandom), w);
      check("rate_beat1", 32'(w), 32'd0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
